random_range_gen: RTL and testbench

Parametrised successor to the team's 32-bit hybrid LFSR/CASR random source, used by the placement engine for move selection. It keeps the same 43-bit LFSR and 37-bit CASR generators and the same XOR-combined 32-bit raw word. It adds:
- a valid/ready output slot;
- a configurable output width;
- optional range scaling to [0, bound);
- a post-seed warm-up discard phase;
- all-zero-seed lockout protection.

---
 rtl/random_range_gen.sv | 170 +++++++++++++++++
 tb/tb_random_range_gen.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_range_gen.sv
// random_range_gen
//
// Hybrid LFSR/CASR random source for move selection in the placement engine.
// A 43-bit Galois LFSR (x^43+x^41+x^20+x+1) and a 37-bit cellular automaton
// ring (rule 90, with rule 150 at cell 27) step together. Their low 32 bits are
// XOR-combined into a 32-bit raw word. That word is either truncated to OUT_W
// bits or scaled into [0, bound_i). The result is then offered through a
// single valid/ready output slot.
//
// After reset or a seed load, the generators first run WARMUP_STEPS steps
// whose output is discarded. An all-zero seed is replaced by the reset state,
// so both generators can never lock up at zero.
//
// Ports
//   clk           clock
//   reset         asynchronous active-high reset
//   seed_valid_i  load seed_i this cycle (highest priority, any state)
//   seed_i        32-bit seed value
//   enable_i      allow the output slot to be filled while running
//   bound_i       range bound; 0 selects the unscaled low OUT_W raw bits
//   rand_valid_o  output slot holds a value
//   rand_ready_i  consumer accepts the slot
//   rand_o        random value held in the slot
//   busy_o        high while the warm-up discard phase is in progress
//
// Handshake: a slot transfer happens on a rising clk edge where
// rand_valid_o && rand_ready_i. While rand_valid_o is high and rand_ready_i is
// low, rand_o and rand_valid_o hold steady, and the generators do not advance.
// A transfer in the same cycle as a seed load still counts as completed.
module random_range_gen #(
  parameter int OUT_W        = 32,
  parameter int WARMUP_STEPS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_valid_i,
  input  logic [31:0]      seed_i,
  input  logic             enable_i,
  input  logic [OUT_W-1:0] bound_i,
  output logic             rand_valid_o,
  input  logic             rand_ready_i,
  output logic [OUT_W-1:0] rand_o,
  output logic             busy_o
);

  localparam int PROD_W = 32 + OUT_W;

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  // With no warm-up requested, both reset and seed load go straight to RUN.
  localparam state_t      START_STATE = (WARMUP_STEPS == 0) ? ST_RUN : ST_WARMUP;
  localparam logic [15:0] START_CNT   = 16'(WARMUP_STEPS);

  // Galois LFSR step: the bit shifted out of the top is folded back in at
  // the polynomial tap positions.
  function automatic logic [42:0] lfsr_next(input logic [42:0] l);
    logic ob;
    ob = l[42];
    lfsr_next = {l[41], l[40] ^ ob, l[39:20], l[19] ^ ob, l[18:1], l[0] ^ ob, ob};
  endfunction

  // Cellular automaton ring step. Cell 27 also keeps its own value (rule 150),
  // which breaks the symmetry of a pure rule-90 ring.
  function automatic logic [36:0] casr_next(input logic [36:0] c);
    logic [36:0] n;
    n = '0;
    for (int i = 0; i < 37; i++) begin
      n[i] = c[(i + 36) % 37] ^ c[(i + 1) % 37];
    end
    n[27] = n[27] ^ c[27];
    return n;
  endfunction

  logic [42:0]       lfsr_q, lfsr_d;
  logic [36:0]       casr_q, casr_d;
  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0]  rand_q, rand_d;
  logic              valid_q, valid_d;
  logic              load;

  logic [31:0]       raw;
  logic [PROD_W-1:0] prod;
  logic [OUT_W-1:0]  scaled;
  logic              unused_prod_lo;

  // The raw word comes from the current (pre-step) generator state.
  assign raw = lfsr_q[31:0] ^ casr_q[31:0];

  // raw/2^32 is a fraction in [0,1); multiplying it by bound_i and keeping
  // the integer part always gives a value strictly below bound_i.
  assign prod           = PROD_W'(raw) * PROD_W'(bound_i);
  assign scaled         = (bound_i == '0) ? raw[OUT_W-1:0] : prod[PROD_W-1:32];
  assign unused_prod_lo = ^prod[31:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    casr_d  = casr_q;
    rand_d  = rand_q;
    valid_d = valid_q;
    load    = 1'b0;

    if (seed_valid_i) begin
      if (seed_i == 32'd0) begin
        lfsr_d = 43'd1;
        casr_d = 37'd1;
      end else begin
        lfsr_d = {11'b0, seed_i};
        casr_d = {5'b0, seed_i};
      end
      // Any held slot is dropped, but rand_o keeps its last value.
      valid_d = 1'b0;
      state_d = START_STATE;
      cnt_d   = START_CNT;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          lfsr_d = lfsr_next(lfsr_q);
          casr_d = casr_next(casr_q);
          cnt_d  = cnt_q - 16'd1;
          if (cnt_q <= 16'd1) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          load = enable_i && (!valid_q || rand_ready_i);
          if (load) begin
            rand_d  = scaled;
            valid_d = 1'b1;
            lfsr_d  = lfsr_next(lfsr_q);
            casr_d  = casr_next(casr_q);
          end else if (valid_q && rand_ready_i) begin
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = START_STATE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= 43'd1;
      casr_q  <= 37'd1;
      state_q <= START_STATE;
      cnt_q   <= START_CNT;
      rand_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      casr_q  <= casr_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rand_q  <= rand_d;
      valid_q <= valid_d;
    end
  end

  assign rand_o       = rand_q;
  assign rand_valid_o = valid_q;
  assign busy_o       = (state_q == ST_WARMUP);

endmodule

// File: tb/tb_random_range_gen.sv
// Testbench for random_range_gen.
//
// Two instances share clk and reset:
//   dut_a: OUT_W=32, WARMUP_STEPS=0
//   dut_b: OUT_W=4,  WARMUP_STEPS=16
//
// The reference model precomputes the raw-word sequence that follows each
// seed. The LFSR is modelled as multiplication by x modulo the polynomial,
// and the CASR as two rotations XORed together. Each model then only tracks
// its position in that sequence, the slot contents and the remaining
// warm-up steps.
module tb_random_range_gen;

  localparam int SEQ_N = 8192;
  localparam logic [63:0] LMASK = 64'h0000_07FF_FFFF_FFFF;
  localparam logic [63:0] LTAPS = 64'h0000_0200_0010_0003;
  localparam logic [63:0] CMASK = 64'h0000_001F_FFFF_FFFF;
  localparam logic [63:0] CBIT27 = 64'h0000_0000_0800_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DUT signals ----------------
  logic        a_seed_valid, a_enable, a_valid, a_ready, a_busy;
  logic [31:0] a_seed, a_bound, a_rand;
  logic        b_seed_valid, b_enable, b_valid, b_ready, b_busy;
  logic [31:0] b_seed;
  logic [3:0]  b_bound, b_rand;

  random_range_gen #(.OUT_W(32), .WARMUP_STEPS(0)) dut_a (
    .clk(clk), .reset(reset), .seed_valid_i(a_seed_valid), .seed_i(a_seed),
    .enable_i(a_enable), .bound_i(a_bound), .rand_valid_o(a_valid),
    .rand_ready_i(a_ready), .rand_o(a_rand), .busy_o(a_busy)
  );

  random_range_gen #(.OUT_W(4), .WARMUP_STEPS(16)) dut_b (
    .clk(clk), .reset(reset), .seed_valid_i(b_seed_valid), .seed_i(b_seed),
    .enable_i(b_enable), .bound_i(b_bound), .rand_valid_o(b_valid),
    .rand_ready_i(b_ready), .rand_o(b_rand), .busy_o(b_busy)
  );

  // ---------------- reference model ----------------
  int unsigned m_seq [2][SEQ_N];
  int          m_idx [2];
  logic        m_valid [2];
  logic [31:0] m_val [2];
  int          m_warm [2];

  // scoreboard for dut_a transfers
  logic [31:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int warm_of(int d);
    return (d == 0) ? 0 : 16;
  endfunction

  function automatic logic [31:0] mask_of(int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  task automatic build_seq(int d, logic [31:0] seed);
    logic [63:0] l, c, rl, rr;
    logic [31:0] s;
    s = (seed == 32'd0) ? 32'd1 : seed;
    l = {32'b0, s};
    c = {32'b0, s};
    for (int k = 0; k < SEQ_N; k++) begin
      m_seq[d][k] = 32'((l ^ c) & 64'hFFFF_FFFF);
      // multiply by x modulo x^43+x^41+x^20+x+1
      l = ((l << 1) & LMASK) ^ (l[42] ? LTAPS : 64'd0);
      // each cell gets left ^ right neighbour; cell 27 keeps its own value too
      rl = ((c << 1) & CMASK) | (c >> 36);
      rr = (c >> 1) | ((c & 64'd1) << 36);
      c = rl ^ rr ^ (c & CBIT27);
    end
  endtask

  function automatic logic [31:0] scale(int d, logic [31:0] raw, logic [31:0] bound);
    logic [63:0] p;
    if (bound == 32'd0) return raw & mask_of(d);
    p = {32'b0, raw} * {32'b0, bound};
    return p[63:32];
  endfunction

  task automatic model_reset(int d);
    build_seq(d, 32'd1);
    m_idx[d]   = 0;
    m_valid[d] = 1'b0;
    m_val[d]   = 32'd0;
    m_warm[d]  = warm_of(d);
    if (d == 0) exp_q.delete();
  endtask

  task automatic model_update(int d, logic sv, logic [31:0] seed, logic en,
                              logic [31:0] bound, logic rdy);
    if (sv) begin
      build_seq(d, seed);
      m_idx[d]   = 0;
      m_valid[d] = 1'b0;
      m_warm[d]  = warm_of(d);
      if (d == 0) exp_q.delete();
    end else if (m_warm[d] > 0) begin
      m_idx[d]  = m_idx[d] + 1;
      m_warm[d] = m_warm[d] - 1;
    end else if (en && (!m_valid[d] || rdy)) begin
      if (m_idx[d] >= SEQ_N) begin
        n_tests++;
        n_fail++;
        $display("FAIL model_range: sequence index %0d, required below %0d", m_idx[d], SEQ_N);
        m_idx[d] = 0;
      end
      m_val[d]   = scale(d, m_seq[d][m_idx[d]], bound);
      m_valid[d] = 1'b1;
      m_idx[d]   = m_idx[d] + 1;
      if (d == 0) exp_q.push_back(m_val[d]);
    end else if (m_valid[d] && rdy) begin
      m_valid[d] = 1'b0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    check({tag, " a_valid"}, 32'(a_valid), 32'(m_valid[0]));
    check({tag, " a_rand"},  a_rand, m_val[0]);
    check({tag, " a_busy"},  32'(a_busy), 32'(m_warm[0] > 0));
    check({tag, " b_valid"}, 32'(b_valid), 32'(m_valid[1]));
    check({tag, " b_rand"},  32'(b_rand), m_val[1]);
    check({tag, " b_busy"},  32'(b_busy), 32'(m_warm[1] > 0));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge with inputs already set: checks a dut_a transfer,
  // lets one rising edge pass, advances the models, then compares at negedge.
  task automatic cycle();
    logic [31:0] e;
    if (a_valid && a_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_a_transfer: got 0x%08h, required no transfer", a_rand);
      end else begin
        e = exp_q.pop_front();
        check("sb_a_transfer", a_rand, e);
      end
    end
    @(posedge clk);
    model_update(0, a_seed_valid, a_seed, a_enable, a_bound, a_ready);
    model_update(1, b_seed_valid, b_seed, b_enable, 32'(b_bound), b_ready);
    @(negedge clk);
    check_outputs("cycle");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset(0);
    model_reset(1);
    check_outputs("reset");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sv;
    logic [31:0] seed;
    logic        en;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_rand;
  } vec_t;

  vec_t vecs [9];

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] hold;
    int          idx_hold;
    int          busy_cnt;
    int          first_valid;
    logic [31:0] val17;

    // back-to-back after reset, then an all-zero seed restarts the sequence
    vecs[0] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[1] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h2};
    vecs[4] = '{1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 32'h2};
    vecs[5] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[8] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h2};

    reset = 1'b1;
    a_seed_valid = 1'b0; a_seed = 32'd0; a_enable = 1'b0; a_bound = 32'd0; a_ready = 1'b0;
    b_seed_valid = 1'b0; b_seed = 32'd0; b_enable = 1'b0; b_bound = 4'd0;  b_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // --- table: first values after reset and zero-seed lockout ---
    for (int k = 0; k < 9; k++) begin
      a_seed_valid = vecs[k].sv;
      a_seed       = vecs[k].seed;
      a_enable     = vecs[k].en;
      a_ready      = vecs[k].rdy;
      a_bound      = 32'd0;
      cycle();
      check($sformatf("vec%0d valid", k), 32'(a_valid), 32'(vecs[k].exp_valid));
      check($sformatf("vec%0d rand", k), a_rand, vecs[k].exp_rand);
    end
    a_seed_valid = 1'b0;

    // --- seed load together with an accepted slot ---
    a_seed_valid = 1'b1;
    a_seed       = 32'hDEAD_BEEF;
    cycle();
    check("seed_hs valid", 32'(a_valid), 32'd0);
    a_seed_valid = 1'b0;
    cycle();
    check("seed_hs first", a_rand, m_seq[0][0]);
    cycle();
    check("seed_hs second", a_rand, m_seq[0][1]);

    // --- warm-up on dut_b: enable toggles while busy ---
    a_enable = 1'b0;
    a_ready  = 1'b0;
    do_reset();
    busy_cnt    = b_busy ? 1 : 0;
    first_valid = -1;
    val17       = 32'hFFFF_FFFF;
    b_ready     = 1'b1;
    b_bound     = 4'd0;
    for (int k = 1; k <= 24; k++) begin
      b_enable = (k >= 17) ? 1'b1 : ($urandom_range(0, 1) == 1);
      cycle();
      if (b_busy) busy_cnt++;
      if (b_valid && first_valid < 0) first_valid = k;
      if (k == 17) val17 = 32'(b_rand);
    end
    check("warmup busy cycles", 32'(busy_cnt), 32'd16);
    check("warmup first valid", 32'(first_valid), 32'd17);
    check("warmup value", val17, m_seq[1][16] & 32'hF);

    // --- backpressure on dut_a ---
    a_enable = 1'b1;
    a_ready  = 1'b1;
    a_bound  = 32'd0;
    for (int k = 0; k < 5; k++) cycle();
    a_ready  = 1'b0;
    hold     = a_rand;
    idx_hold = m_idx[0];
    for (int k = 0; k < 10; k++) begin
      a_enable = ($urandom_range(0, 1) == 1);
      a_bound  = $urandom();
      cycle();
      check($sformatf("stall%0d rand", k), a_rand, hold);
      check($sformatf("stall%0d valid", k), 32'(a_valid), 32'd1);
    end
    a_enable = 1'b1;
    a_bound  = 32'd0;
    a_ready  = 1'b1;
    cycle();
    check("stall release no skip", a_rand, m_seq[0][idx_hold]);

    // --- randomized traffic on both instances ---
    for (int k = 0; k < 1500; k++) begin
      a_seed_valid = ($urandom_range(0, 199) == 0);
      a_seed       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      a_enable     = ($urandom_range(0, 3) != 0);
      a_ready      = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 2))
        0:       a_bound = 32'd0;
        1:       a_bound = $urandom();
        default: a_bound = 32'($urandom_range(1, 100));
      endcase
      b_seed_valid = ($urandom_range(0, 199) == 0);
      b_seed       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      b_enable     = ($urandom_range(0, 3) != 0);
      b_ready      = ($urandom_range(0, 2) != 0);
      b_bound      = 4'($urandom_range(0, 15));
      cycle();
    end
    a_seed_valid = 1'b0;
    b_seed_valid = 1'b0;

    // --- range scaling ---
    do_reset();
    a_enable = 1'b1;
    a_ready  = 1'b1;
    a_bound  = 32'd1;
    b_bound  = 4'd0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      check("bound1 zero", a_rand, 32'd0);
    end
    a_bound = 32'd10;
    for (int k = 0; k < 2000; k++) begin
      a_ready  = ($urandom_range(0, 3) != 0);
      b_enable = ($urandom_range(0, 3) != 0);
      b_ready  = ($urandom_range(0, 3) != 0);
      cycle();
      if (a_valid) check("bound10 below", 32'(a_rand < 32'd10), 32'd1);
    end

    // --- asynchronous reset in the middle of a cycle ---
    a_enable = 1'b1;
    a_ready  = 1'b1;
    a_bound  = 32'd0;
    for (int k = 0; k < 8; k++) cycle();
    #2;
    reset = 1'b1;
    #1;
    check("async a_valid", 32'(a_valid), 32'd0);
    check("async a_rand", a_rand, 32'd0);
    check("async b_valid", 32'(b_valid), 32'd0);
    check("async b_rand", 32'(b_rand), 32'd0);
    check("async b_busy", 32'(b_busy), 32'd1);
    @(negedge clk);
    do_reset();
    cycle();
    check("after async first", a_rand, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
